pipe_stage_buf: RTL and testbench
=================================

Name: pipe_stage_buf

Overview:
Parametrised pipeline stage register that replaces the fixed-field, enable-only stage registers between pipeline stages (e.g. Decode->Issue). It carries an opaque WIDTH-bit payload with a valid/ready handshake, a flush input and an optional skid entry, so the upstream ready is fully registered. It also provides a saturating stall counter for performance monitoring.

Parameters:
WIDTH, 64, payload width in bits (packed control and data fields of the stage)
SKID, 1, 0 = single register with combinational ready; 1 = main + skid register with registered ready
CNT_W, 16, width of the stall counter

Ports:
CLK  input  1  clock; all state updates on rising edge
Reset  input  1  asynchronous, active-high reset
Flush  input  1  synchronous squash of all held entries (branch mispredict / exception)
InValid  input  1  upstream offers InData this cycle
InReady  output  1  stage accepts this cycle; in-fire = InValid & InReady
InData  input  WIDTH  upstream payload
OutValid  output  1  OutData is valid
OutReady  input  1  downstream accepts; out-fire = OutValid & OutReady
OutData  output  WIDTH  payload to downstream
StallCnt  output  CNT_W  cycles with OutValid=1 and OutReady=0, saturating

Behaviour:
- Reset (async, any cycle, including mid-transfer): all entries empty; OutValid=0; OutData=0; skid data=0; StallCnt=0. InReady=1 per the decode rules below. Entries in flight are lost.
- Latency: an accepted word appears on OutData on the cycle after in-fire, regardless of SKID.
- Payload is captured only on in-fire. OutData holds its value while OutValid=1 and OutReady=0.
- SKID=0:
  - InReady = ~OutValid | OutReady. This is combinational.
  - On in-fire: OutData<=InData and OutValid<=1.
  - Else, on out-fire: OutValid<=0.
  - Simultaneous in-fire and out-fire: the register is replaced and OutValid stays 1.
- SKID=1: state machine with states EMPTY, BUSY (main full) and FULL (main + skid full).
  - OutValid = (state != EMPTY). OutData = main register.
  - InReady = (state != FULL). It decodes from the state flops only; there is no combinational path from OutReady or InValid.
  - EMPTY: in-fire -> BUSY, main<=InData.
  - BUSY:
    - in-fire & out-fire -> BUSY, main<=InData.
    - in-fire & no out-fire -> FULL, skid<=InData.
    - out-fire & no in-fire -> EMPTY.
    - otherwise hold.
  - FULL: out-fire -> BUSY, main<=skid. No in-fire is possible because InReady=0.
  - Ordering is strictly FIFO: main is always older than skid.
- Flush (either SKID mode):
  - Next state EMPTY / OutValid=0. This overrides any in-fire or out-fire in the same cycle.
  - The word offered on InData that cycle is dropped, even if InReady=1.
  - Data registers are not cleared.
  - Downstream may still see out-fire in the flush cycle. That transfer counts as delivered; the stage does not retract it.
- StallCnt:
  - +1 on each clock where OutValid=1 and OutReady=0, including the flush cycle if the condition holds.
  - Saturates at 2^CNT_W-1; there is no wrap.
  - Cleared only by Reset. Flush does not clear it.
- X-safety: InData is ignored when InValid=0. OutReady is ignored when OutValid=0.

Test Plan:
- Reset mid-operation: SKID=1, fill FULL with 0xA/0xB, assert Reset asynchronously between edges -> OutValid=0, OutData=0, InReady=1, StallCnt=0 immediately, without waiting for a clock.
- Streaming: SKID=1, OutReady=1, InValid=1 with 0x1..0x8 on consecutive cycles -> OutData shows 0x1..0x8 one cycle later, no bubbles, InReady stays 1, StallCnt=0.
- Backpressure: OutReady=0, send 0xA then 0xB -> state FULL, InReady=0 on the next cycle, OutData=0xA held; raise OutReady -> 0xA then 0xB delivered in order, InReady returns to 1. StallCnt equals the number of stalled cycles.
- Flush precedence: in FULL state assert Flush with InValid=1, InData=0xC, OutReady=0 -> next cycle OutValid=0 and InReady=1; 0xA, 0xB and 0xC are never delivered.
- Saturation: CNT_W=4, hold OutValid=1 and OutReady=0 for 20 cycles -> StallCnt reaches 15 and stays at 15. Flush then leaves it at 15.
- SKID=0 mode: OutValid=1 with OutReady toggling -> InReady follows OutReady in the same cycle. Simultaneous in-fire/out-fire replaces OutData and keeps OutValid=1. A Flush cycle drops the offered word.

Source files
------------

// File: rtl/pipe_stage_buf.sv
// Pipeline stage register with valid/ready handshake, flush and an optional skid entry.
// A saturating counter records how many cycles the output was held back by downstream.
module pipe_stage_buf #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned SKID  = 1,
    parameter int unsigned CNT_W = 16
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             Flush,
    input  logic             InValid,
    output logic             InReady,
    input  logic [WIDTH-1:0] InData,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] OutData,
    output logic [CNT_W-1:0] StallCnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   main_q, main_d;
    logic [WIDTH-1:0]   skid_q, skid_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

    logic in_fire;
    logic out_fire;
    logic stall;

    // Without a skid entry, ready must look through to OutReady so a full
    // register can be replaced in the same cycle it drains.
    always_comb begin
        OutValid = (state_q != ST_EMPTY);
        OutData  = main_q;
        StallCnt = stall_cnt_q;
        if (SKID != 0) begin
            InReady = (state_q != ST_FULL);
        end else begin
            InReady = !OutValid || OutReady;
        end
        in_fire  = InValid && InReady;
        out_fire = OutValid && OutReady;
        stall    = OutValid && !OutReady;
    end

    // NOTE: every signal written here gets a default first, so no path can leave a latch behind.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        case (state_q)
            ST_EMPTY: begin
                if (in_fire) begin
                    state_d = ST_BUSY;
                    main_d  = InData;
                end
            end
            ST_BUSY: begin
                if (in_fire && out_fire) begin
                    main_d = InData;
                end else if (in_fire && (SKID != 0)) begin
                    state_d = ST_FULL;
                    skid_d  = InData;
                end else if (out_fire) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // The skid word is always the younger one, so it moves up on drain.
                if (out_fire) begin
                    state_d = ST_BUSY;
                    main_d  = skid_q;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase

        // Flush squashes everything held and drops the word offered this cycle;
        // the data registers simply keep their stale contents.
        if (Flush) begin
            state_d = ST_EMPTY;
            main_d  = main_q;
            skid_d  = skid_q;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
    // NOTE: the data registers are reset too, since OutData must read zero out of reset.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q     <= ST_EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Self-checking bench for pipe_stage_buf: skid and non-skid instances compared
// against a FIFO-level reference model, plus directed reset/flush/saturation scenarios.
module tb_pipe_stage_buf;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        flush1 = 1'b0, in_valid1 = 1'b0, out_ready1 = 1'b0;
    logic [63:0] in_data1 = '0;
    logic        in_ready1, out_valid1, in_ready4, out_valid4;
    logic [63:0] out_data1, out_data4;
    logic [15:0] stall1;
    logic [3:0]  stall4;

    logic        flush0 = 1'b0, in_valid0 = 1'b0, out_ready0 = 1'b0;
    logic [63:0] in_data0 = '0;
    logic        in_ready0, out_valid0;
    logic [63:0] out_data0;
    logic [15:0] stall0;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the stage is a FIFO of depth 2 (skid) or 1 (no skid).
    logic [63:0] q1[$];
    logic [63:0] q0[$];
    int unsigned cnt1 = 0, cnt4 = 0, cnt0 = 0;

    always #5 clk = ~clk;

    pipe_stage_buf #(.WIDTH(64), .SKID(1), .CNT_W(16)) u_s1 (
        .CLK(clk), .Reset(rst), .Flush(flush1), .InValid(in_valid1), .InReady(in_ready1),
        .InData(in_data1), .OutValid(out_valid1), .OutReady(out_ready1), .OutData(out_data1),
        .StallCnt(stall1));

    pipe_stage_buf #(.WIDTH(64), .SKID(1), .CNT_W(4)) u_s4 (
        .CLK(clk), .Reset(rst), .Flush(flush1), .InValid(in_valid1), .InReady(in_ready4),
        .InData(in_data1), .OutValid(out_valid4), .OutReady(out_ready1), .OutData(out_data4),
        .StallCnt(stall4));

    pipe_stage_buf #(.WIDTH(64), .SKID(0), .CNT_W(16)) u_s0 (
        .CLK(clk), .Reset(rst), .Flush(flush0), .InValid(in_valid0), .InReady(in_ready0),
        .InData(in_data0), .OutValid(out_valid0), .OutReady(out_ready0), .OutData(out_data0),
        .StallCnt(stall0));

    task automatic model_reset();
        q1.delete();
        q0.delete();
        cnt1 = 0;
        cnt4 = 0;
        cnt0 = 0;
    endtask

    // Advances the model by one clock using the inputs currently applied.
    task automatic model_step();
        bit acc, del;
        if (q1.size() > 0 && !out_ready1) begin
            if (cnt1 < 65535) cnt1++;
            if (cnt4 < 15) cnt4++;
        end
        acc = in_valid1 && (q1.size() < 2);
        del = (q1.size() > 0) && out_ready1;
        if (flush1) q1.delete();
        else begin
            if (del) void'(q1.pop_front());
            if (acc) q1.push_back(in_data1);
        end
        if (q0.size() > 0 && !out_ready0 && cnt0 < 65535) cnt0++;
        acc = in_valid0 && (q0.size() == 0 || out_ready0);
        del = (q0.size() > 0) && out_ready0;
        if (flush0) q0.delete();
        else begin
            if (del) void'(q0.pop_front());
            if (acc) q0.push_back(in_data0);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush1 = 0; in_valid1 = 0; out_ready1 = 0; in_data1 = '0;
        flush0 = 0; in_valid0 = 0; out_ready0 = 0; in_data0 = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        model_reset();
        #1 rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        #2 rst = 1'b1;
        model_reset();
        #1;
        n_checks++; if (out_valid1 !== 1'b0 || out_valid0 !== 1'b0 || out_valid4 !== 1'b0) begin
            n_fail++; $display("FAIL reset_out_valid: got %b%b%b want 000", out_valid1, out_valid0, out_valid4); end
        n_checks++; if (out_data1 !== 64'h0 || out_data0 !== 64'h0 || out_data4 !== 64'h0) begin
            n_fail++; $display("FAIL reset_out_data: got %h/%h/%h want 0", out_data1, out_data0, out_data4); end
        n_checks++; if (in_ready1 !== 1'b1 || in_ready0 !== 1'b1 || in_ready4 !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready: got %b%b%b want 111", in_ready1, in_ready0, in_ready4); end
        n_checks++; if (stall1 !== 16'h0 || stall0 !== 16'h0 || stall4 !== 4'h0) begin
            n_fail++; $display("FAIL reset_stall: got %0d/%0d/%0d want 0", stall1, stall0, stall4); end
        #3 rst = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        in_valid1 = 1; in_data1 = 64'hA; out_ready1 = 0;
        tick();
        in_data1 = 64'hB;
        tick();
        in_valid1 = 0;
        #1;
        n_checks++; if (in_ready1 !== 1'b0 || out_data1 !== 64'hA) begin
            n_fail++; $display("FAIL mid_reset_full: ready %b data %h want 0 / a", in_ready1, out_data1); end
        #1 rst = 1'b1;
        model_reset();
        #1;
        n_checks++; if (out_valid1 !== 1'b0 || in_ready1 !== 1'b1 || out_data1 !== 64'h0 || stall1 !== 16'h0) begin
            n_fail++; $display("FAIL mid_reset_async: valid %b ready %b data %h stall %0d want 0 1 0 0",
                               out_valid1, in_ready1, out_data1, stall1); end
        #1 rst = 1'b0;
        tick();
    endtask

    task automatic test_streaming();
        do_reset();
        out_ready1 = 1;
        for (int i = 1; i <= 9; i++) begin
            in_valid1 = (i <= 8);
            in_data1  = 64'(i);
            #1;
            n_checks++; if (in_ready1 !== 1'b1) begin
                n_fail++; $display("FAIL stream_in_ready[%0d]: got %b want 1", i, in_ready1); end
            if (i > 1) begin
                n_checks++; if (out_valid1 !== 1'b1 || out_data1 !== 64'(i - 1)) begin
                    n_fail++; $display("FAIL stream_out[%0d]: valid %b data %h want 1 %h", i, out_valid1, out_data1, i - 1); end
            end
            tick();
        end
        n_checks++; if (out_valid1 !== 1'b0 || stall1 !== 16'h0) begin
            n_fail++; $display("FAIL stream_end: valid %b stall %0d want 0 0", out_valid1, stall1); end
    endtask

    task automatic test_backpressure();
        do_reset();
        in_valid1 = 1; in_data1 = 64'hA; out_ready1 = 0;
        tick();
        in_data1 = 64'hB;
        #1;
        n_checks++; if (out_data1 !== 64'hA || in_ready1 !== 1'b1) begin
            n_fail++; $display("FAIL bp_busy: data %h ready %b want a 1", out_data1, in_ready1); end
        tick();
        in_valid1 = 0;
        for (int k = 1; k <= 2; k++) begin
            #1;
            n_checks++; if (in_ready1 !== 1'b0 || out_data1 !== 64'hA || stall1 !== 16'(k)) begin
                n_fail++; $display("FAIL bp_hold[%0d]: ready %b data %h stall %0d want 0 a %0d", k, in_ready1, out_data1, stall1, k); end
            tick();
        end
        out_ready1 = 1;
        #1;
        n_checks++; if (out_valid1 !== 1'b1 || out_data1 !== 64'hA || stall1 !== 16'd3) begin
            n_fail++; $display("FAIL bp_drain_a: valid %b data %h stall %0d want 1 a 3", out_valid1, out_data1, stall1); end
        tick();
        n_checks++; if (out_valid1 !== 1'b1 || out_data1 !== 64'hB || in_ready1 !== 1'b1) begin
            n_fail++; $display("FAIL bp_drain_b: valid %b data %h ready %b want 1 b 1", out_valid1, out_data1, in_ready1); end
        tick();
        n_checks++; if (out_valid1 !== 1'b0 || stall1 !== 16'd3) begin
            n_fail++; $display("FAIL bp_done: valid %b stall %0d want 0 3", out_valid1, stall1); end
    endtask

    task automatic test_flush();
        do_reset();
        in_valid1 = 1; in_data1 = 64'hA; out_ready1 = 0;
        tick();
        in_data1 = 64'hB;
        tick();
        flush1 = 1; in_data1 = 64'hC;
        tick();
        flush1 = 0; in_valid1 = 0; out_ready1 = 1;
        #1;
        n_checks++; if (out_valid1 !== 1'b0 || in_ready1 !== 1'b1 || stall1 !== 16'd2) begin
            n_fail++; $display("FAIL flush_empty: valid %b ready %b stall %0d want 0 1 2", out_valid1, in_ready1, stall1); end
        tick();
        in_valid1 = 1; in_data1 = 64'hD;
        #1;
        n_checks++; if (out_valid1 !== 1'b0) begin
            n_fail++; $display("FAIL flush_no_ghost: valid %b want 0", out_valid1); end
        tick();
        in_valid1 = 0;
        #1;
        n_checks++; if (out_valid1 !== 1'b1 || out_data1 !== 64'hD) begin
            n_fail++; $display("FAIL flush_resume: valid %b data %h want 1 d", out_valid1, out_data1); end
        tick();
    endtask

    task automatic test_saturation();
        do_reset();
        in_valid1 = 1; in_data1 = 64'h55; out_ready1 = 0;
        tick();
        in_valid1 = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            n_checks++; if (stall4 !== 4'((k > 15) ? 15 : k) || stall1 !== 16'(k)) begin
                n_fail++; $display("FAIL sat[%0d]: cnt4 %0d cnt16 %0d want %0d %0d", k, stall4, stall1, (k > 15) ? 15 : k, k); end
        end
        flush1 = 1;
        tick();
        flush1 = 0;
        tick();
        n_checks++; if (stall4 !== 4'd15 || stall1 !== 16'd21 || out_valid4 !== 1'b0) begin
            n_fail++; $display("FAIL sat_flush: cnt4 %0d cnt16 %0d valid %b want 15 21 0", stall4, stall1, out_valid4); end
    endtask

    task automatic test_skid0();
        do_reset();
        in_valid0 = 1; in_data0 = 64'h1; out_ready0 = 0;
        #1;
        n_checks++; if (in_ready0 !== 1'b1) begin
            n_fail++; $display("FAIL s0_empty_ready: got %b want 1", in_ready0); end
        tick();
        in_valid0 = 0;
        #1;
        n_checks++; if (out_valid0 !== 1'b1 || out_data0 !== 64'h1 || in_ready0 !== 1'b0) begin
            n_fail++; $display("FAIL s0_held: valid %b data %h ready %b want 1 1 0", out_valid0, out_data0, in_ready0); end
        out_ready0 = 1;
        #1;
        n_checks++; if (in_ready0 !== 1'b1) begin
            n_fail++; $display("FAIL s0_ready_follow_hi: got %b want 1", in_ready0); end
        out_ready0 = 0;
        #1;
        n_checks++; if (in_ready0 !== 1'b0) begin
            n_fail++; $display("FAIL s0_ready_follow_lo: got %b want 0", in_ready0); end
        in_valid0 = 1; in_data0 = 64'h2; out_ready0 = 1;
        tick();
        in_valid0 = 0; out_ready0 = 0;
        #1;
        n_checks++; if (out_valid0 !== 1'b1 || out_data0 !== 64'h2) begin
            n_fail++; $display("FAIL s0_replace: valid %b data %h want 1 2", out_valid0, out_data0); end
        in_valid0 = 1; in_data0 = 64'h3; out_ready0 = 1; flush0 = 1;
        tick();
        flush0 = 0; in_valid0 = 0; out_ready0 = 0;
        #1;
        n_checks++; if (out_valid0 !== 1'b0 || in_ready0 !== 1'b1) begin
            n_fail++; $display("FAIL s0_flush_drop: valid %b ready %b want 0 1", out_valid0, in_ready0); end
        tick();
    endtask

    task automatic test_random();
        logic exp_v1, exp_r1, exp_v0, exp_r0;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            in_valid1  = ($urandom_range(0, 3) != 0);
            in_data1   = {$urandom, $urandom};
            out_ready1 = ($urandom_range(0, 9) < ((i < 300) ? 4 : 8));
            flush1     = ($urandom_range(0, 24) == 0);
            in_valid0  = ($urandom_range(0, 2) != 0);
            in_data0   = {$urandom, $urandom};
            out_ready0 = ($urandom_range(0, 1) != 0);
            flush0     = ($urandom_range(0, 24) == 0);
            #1;
            exp_v1 = (q1.size() > 0);
            exp_r1 = (q1.size() < 2);
            exp_v0 = (q0.size() > 0);
            exp_r0 = (q0.size() == 0) || out_ready0;
            n_checks++; if ({out_valid1, in_ready1, out_valid4, in_ready4} !== {exp_v1, exp_r1, exp_v1, exp_r1}) begin
                n_fail++; $display("FAIL rnd_s1_hs[%0d]: got %b%b%b%b want %b%b%b%b", i, out_valid1, in_ready1,
                                   out_valid4, in_ready4, exp_v1, exp_r1, exp_v1, exp_r1); end
            if (exp_v1) begin
                n_checks++; if (out_data1 !== q1[0] || out_data4 !== q1[0]) begin
                    n_fail++; $display("FAIL rnd_s1_data[%0d]: got %h/%h want %h", i, out_data1, out_data4, q1[0]); end
            end
            n_checks++; if (stall1 !== 16'(cnt1) || stall4 !== 4'(cnt4)) begin
                n_fail++; $display("FAIL rnd_s1_stall[%0d]: got %0d/%0d want %0d/%0d", i, stall1, stall4, cnt1, cnt4); end
            n_checks++; if ({out_valid0, in_ready0} !== {exp_v0, exp_r0}) begin
                n_fail++; $display("FAIL rnd_s0_hs[%0d]: got %b%b want %b%b", i, out_valid0, in_ready0, exp_v0, exp_r0); end
            if (exp_v0) begin
                n_checks++; if (out_data0 !== q0[0]) begin
                    n_fail++; $display("FAIL rnd_s0_data[%0d]: got %h want %h", i, out_data0, q0[0]); end
            end
            n_checks++; if (stall0 !== 16'(cnt0)) begin
                n_fail++; $display("FAIL rnd_s0_stall[%0d]: got %0d want %0d", i, stall0, cnt0); end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid();
        test_streaming();
        test_backpressure();
        test_flush();
        test_saturation();
        test_skid0();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
